// File: rtl/ow_pkg.sv
// Shared One-Wire definitions: command encodings, scheduler states and header packing.
// Also imported by the APB-side register block.
package ow_pkg;

  localparam logic [3:0] OW_CMD_RESET = 4'h1;
  localparam logic [3:0] OW_CMD_WRITE = 4'h2;
  localparam logic [3:0] OW_CMD_READ  = 4'h3;

  typedef enum logic [2:0] {
    OW_IDLE,
    OW_HDR,
    OW_WDATA,
    OW_RSP,
    OW_DONE
  } ow_state_e;

  // A bus reset carries no length on the wire.
  function automatic logic [7:0] ow_hdr_pack(input logic [3:0] cmd, input logic [3:0] len);
    return (cmd == OW_CMD_RESET) ? {cmd, 4'h0} : {cmd, len};
  endfunction

  function automatic logic ow_cmd_legal(input logic [3:0] cmd);
    return (cmd == OW_CMD_RESET) || (cmd == OW_CMD_WRITE) || (cmd == OW_CMD_READ);
  endfunction

endpackage

// File: rtl/ow_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus binary index, pointer moves past the
// winner on each advance strobe.
module ow_rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index
);

  logic [IW-1:0]  ptr;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW:0]    sum;
  logic           found;

  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[N-1:0];
    index = ptr;
    sum   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + (IW+1)'(k);
        if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
        index = sum[IW-1:0];
      end
    end
    grant = found ? (N'(1) << index) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (index == IW'(N-1)) ? '0 : index + IW'(1);
    end
  end

endmodule

// File: rtl/ow_phy_scheduler.sv
// Arbitrates requesters onto the One-Wire PHY, serialises header/data bytes and
// routes read-back bytes to the granted requester.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  OW_IDLE  | wait for a descriptor, latch grant/cmd/len
//  OW_HDR   | push {cmd,len} header once the PHY FIFO has room
//  OW_WDATA | push len write bytes, popping the requester FIFO alongside
//  OW_RSP   | forward read-back bytes, watch the per-byte timeout
//  OW_DONE  | req_done/req_err visible for the granted requester
module ow_phy_scheduler
  import ow_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [4*NUM_REQ-1:0] req_cmd,
  input  logic [4*NUM_REQ-1:0] req_len,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   req_wdata_rd,
  output logic [NUM_REQ-1:0]   req_done,
  output logic                 req_err,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [7:0]           rsp_data,
  input  logic                 phy_wr_full,
  output logic                 phy_wr_en,
  output logic [7:0]           phy_wr_data,
  input  logic                 phy_rd_en,
  input  logic [7:0]           phy_rd_data,
  output logic                 busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  ow_state_e          state;
  logic [IW-1:0]      g;
  logic [NUM_REQ-1:0] g_oh;
  logic [3:0]         cmd, len, bcnt, rsp_last;
  logic [TW-1:0]      tcnt;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IW-1:0]      arb_index;
  logic [3:0]         sel_cmd, sel_len;
  logic [7:0]         sel_wdata;
  logic               wr_slot, noop;

  ow_rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (state == OW_IDLE),
    .grant   (arb_grant),
    .index   (arb_index)
  );

  assign g_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << g;

  always_comb begin
    sel_cmd   = '0;
    sel_len   = '0;
    sel_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (arb_grant[k]) begin
        sel_cmd = req_cmd[4*k +: 4];
        sel_len = req_len[4*k +: 4];
      end
      if (g_oh[k]) sel_wdata = req_wdata[8*k +: 8];
    end
  end

  assign noop     = ((sel_cmd == OW_CMD_WRITE) || (sel_cmd == OW_CMD_READ)) && (sel_len == 4'd0);
  assign rsp_last = (cmd == OW_CMD_RESET) ? 4'd0 : len - 4'd1;

  // Push and pop are decoded from state so a first-word-fall-through source
  // can be drained one byte per cycle and a full FIFO is never written.
  assign wr_slot      = ((state == OW_HDR) || (state == OW_WDATA)) && !phy_wr_full;
  assign phy_wr_en    = wr_slot;
  assign phy_wr_data  = !wr_slot ? 8'h00 : (state == OW_HDR) ? ow_hdr_pack(cmd, len) : sel_wdata;
  assign req_wdata_rd = (wr_slot && (state == OW_WDATA)) ? g_oh : '0;
  assign busy         = (state != OW_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= OW_IDLE;
      g         <= '0;
      cmd       <= '0;
      len       <= '0;
      bcnt      <= '0;
      tcnt      <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      req_done  <= '0;
      req_err   <= 1'b0;
    end else begin
      rsp_valid <= '0;
      req_done  <= '0;
      req_err   <= 1'b0;
      case (state)
        OW_IDLE: begin
          if (|req_valid) begin
            g    <= arb_index;
            cmd  <= sel_cmd;
            len  <= sel_len;
            bcnt <= '0;
            tcnt <= '0;
            if (!ow_cmd_legal(sel_cmd)) begin
              state    <= OW_DONE;
              req_done <= arb_grant;
              req_err  <= 1'b1;
            end else if (noop) begin
              state    <= OW_DONE;
              req_done <= arb_grant;
            end else begin
              state <= OW_HDR;
            end
          end
        end
        OW_HDR: begin
          if (!phy_wr_full) state <= (cmd == OW_CMD_WRITE) ? OW_WDATA : OW_RSP;
        end
        OW_WDATA: begin
          if (!phy_wr_full) begin
            if (bcnt == len - 4'd1) begin
              state    <= OW_DONE;
              req_done <= g_oh;
            end else begin
              bcnt <= bcnt + 4'd1;
            end
          end
        end
        OW_RSP: begin
          // A byte landing on the timeout cycle wins over the timeout.
          if (phy_rd_en) begin
            rsp_valid <= g_oh;
            rsp_data  <= phy_rd_data;
            tcnt      <= '0;
            if (bcnt == rsp_last) begin
              state    <= OW_DONE;
              req_done <= g_oh;
            end else begin
              bcnt <= bcnt + 4'd1;
            end
          end else if (tcnt == T_LAST) begin
            state    <= OW_DONE;
            req_done <= g_oh;
            req_err  <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        OW_DONE: state <= OW_IDLE;
        default: state <= OW_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ow_phy_scheduler.sv
// Scoreboard bench for ow_phy_scheduler: directed transactions push expected
// PHY bytes, responses and completions; a negedge monitor pops and compares.
module tb_ow_phy_scheduler;
  localparam int NR = 2;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid;
  logic [4*NR-1:0] req_cmd, req_len;
  logic [8*NR-1:0] req_wdata;
  logic [NR-1:0] req_wdata_rd, req_done, rsp_valid;
  logic          req_err;
  logic [7:0]    rsp_data;
  logic          phy_wr_full, phy_wr_en, phy_rd_en, busy;
  logic [7:0]    phy_wr_data, phy_rd_data;

  always #5 clk = ~clk;

  ow_phy_scheduler #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_cmd(req_cmd), .req_len(req_len),
    .req_wdata(req_wdata), .req_wdata_rd(req_wdata_rd), .req_done(req_done), .req_err(req_err),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .phy_wr_full(phy_wr_full), .phy_wr_en(phy_wr_en),
    .phy_wr_data(phy_wr_data), .phy_rd_en(phy_rd_en), .phy_rd_data(phy_rd_data), .busy(busy)
  );

  int n_checks = 0, n_fail = 0;
  int cyc = 0, push_cnt = 0, done_cnt = 0, rsp_cnt = 0, done_cyc = 0;
  int rd_cnt0 = 0, rd_cnt1 = 0;
  int push_cyc[$];
  logic [7:0]    exp_push[$];
  logic [NR+7:0] exp_rsp[$];
  logic [NR:0]   exp_done[$];
  logic [7:0]    wq0[$], wq1[$];
  logic [NR-1:0] rd_s = '0, done_s = '0;
  bit stim_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, want);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got 0x%0h, required no event", name, act);
  endtask

  function automatic logic [24:0] outs();
    return {phy_wr_en, phy_wr_data, req_wdata_rd, req_done, req_err, rsp_valid, rsp_data, busy};
  endfunction

  function automatic logic [NR-1:0] oh(input int r);
    return (r == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic add_rsp(input int r, input logic [7:0] d);
    exp_rsp.push_back({oh(r), d});
  endtask

  task automatic add_done(input int r, input logic e);
    exp_done.push_back({oh(r), e});
  endtask

  task automatic upd_wdata();
    req_wdata[7:0]  = (wq0.size() > 0) ? wq0[0] : 8'h00;
    req_wdata[15:8] = (wq1.size() > 0) ? wq1[0] : 8'h00;
  endtask

  // Requester FIFOs pop and requesters drop req_valid based on the previous cycle.
  task automatic step();
    logic [7:0] tmp;
    @(posedge clk);
    #1;
    if (rd_s[0] && wq0.size() > 0) tmp = wq0.pop_front();
    if (rd_s[1] && wq1.size() > 0) tmp = wq1.pop_front();
    if (done_s[0]) req_valid[0] = 1'b0;
    if (done_s[1]) req_valid[1] = 1'b0;
    upd_wdata();
  endtask

  task automatic issue(input int r, input logic [3:0] c, input logic [3:0] l);
    if (r == 0) begin
      req_cmd[3:0] = c; req_len[3:0] = l; req_valid[0] = 1'b1;
    end else begin
      req_cmd[7:4] = c; req_len[7:4] = l; req_valid[1] = 1'b1;
    end
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int k = 0;
    while (done_cnt < target && k < budget) begin step(); k++; end
    if (done_cnt < target) begin
      n_checks++; n_fail++;
      $display("FAIL %s: done count %0d, required %0d within %0d cycles", name, done_cnt, target, budget);
    end
  endtask

  task automatic wait_push(input int target, input int budget, input string name);
    int k = 0;
    while (push_cnt < target && k < budget) begin step(); k++; end
    if (push_cnt < target) begin
      n_checks++; n_fail++;
      $display("FAIL %s: push count %0d, required %0d within %0d cycles", name, push_cnt, target, budget);
    end
  endtask

  task automatic monitor_once();
    @(negedge clk);
    cyc++;
    rd_s   = req_wdata_rd;
    done_s = req_done;
    rd_cnt0 += int'(req_wdata_rd[0]);
    rd_cnt1 += int'(req_wdata_rd[1]);
    if (phy_wr_en) begin
      chk("push_while_full", phy_wr_full, 1'b0);
      push_cnt++;
      push_cyc.push_back(cyc);
      if (exp_push.size() == 0) unexpected("push_unexpected", phy_wr_data);
      else chk("push_data", phy_wr_data, exp_push.pop_front());
    end
    if (rsp_valid != '0) begin
      rsp_cnt++;
      if (exp_rsp.size() == 0) unexpected("rsp_unexpected", {rsp_valid, rsp_data});
      else chk("rsp_valid_data", {rsp_valid, rsp_data}, exp_rsp.pop_front());
    end
    if (req_done != '0) begin
      done_cnt++;
      done_cyc = cyc;
      if (exp_done.size() == 0) unexpected("done_unexpected", {req_done, req_err});
      else chk("done_err", {req_done, req_err}, exp_done.pop_front());
    end
  endtask

  task automatic stimulus();
    int base, p0, r0, clr;
    rst = 1'b1; req_valid = '0; req_cmd = '0; req_len = '0; req_wdata = '0;
    phy_wr_full = 1'b0; phy_rd_en = 1'b0; phy_rd_data = '0;
    repeat (3) step();
    chk("reset_outputs", outs(), '0);
    rst = 1'b0;
    step();
    chk("idle_after_reset", busy, 1'b0);

    // T1: requester 0 WRITE len 3
    wq0 = '{8'hCC, 8'h44, 8'hBE}; upd_wdata();
    base = push_cyc.size();
    exp_push.push_back(8'h23); exp_push.push_back(8'hCC);
    exp_push.push_back(8'h44); exp_push.push_back(8'hBE);
    add_done(0, 1'b0);
    issue(0, 4'h2, 4'd3);
    wait_done(done_cnt + 1, 30, "t1_done_wait");
    chk("t1_wdata_rd_pulses", rd_cnt0, 3);
    chk("t1_src_drained", wq0.size(), 0);
    if (push_cyc.size() >= base + 4) begin
      chk("t1_push_span", push_cyc[base+3] - push_cyc[base], 3);
      chk("t1_done_latency", done_cyc - push_cyc[base+3], 1);
    end else unexpected("t1_push_count", push_cyc.size() - base);
    chk("t1_idle", busy, 1'b0);

    // T2: requester 1 READ len 2
    exp_push.push_back(8'h32);
    add_rsp(1, 8'h5A); add_rsp(1, 8'hA5); add_done(1, 1'b0);
    issue(1, 4'h3, 4'd2);
    wait_push(push_cnt + 1, 20, "t2_hdr_wait");
    phy_rd_en = 1'b1; phy_rd_data = 8'h5A; step();
    phy_rd_data = 8'hA5; step();
    phy_rd_en = 1'b0;
    wait_done(done_cnt + 1, 20, "t2_done_wait");

    // T3: both requesters, then requester 0 re-requests
    wq0 = '{8'h11}; wq1 = '{8'h22}; upd_wdata();
    exp_push.push_back(8'h21); exp_push.push_back(8'h11);
    exp_push.push_back(8'h21); exp_push.push_back(8'h22);
    exp_push.push_back(8'h21); exp_push.push_back(8'h33);
    add_done(0, 1'b0); add_done(1, 1'b0); add_done(0, 1'b0);
    issue(0, 4'h2, 4'd1); issue(1, 4'h2, 4'd1);
    wait_done(done_cnt + 1, 20, "t3_first_wait");
    wq0.push_back(8'h33); upd_wdata();
    issue(0, 4'h2, 4'd1);
    wait_done(done_cnt + 2, 40, "t3_rest_wait");

    // T4: RESET while the PHY FIFO is full for 10 cycles
    phy_wr_full = 1'b1;
    p0 = push_cnt;
    exp_push.push_back(8'h10); add_rsp(0, 8'h01); add_done(0, 1'b0);
    issue(0, 4'h1, 4'd0);
    repeat (10) step();
    chk("t4_no_push_while_full", push_cnt, p0);
    chk("t4_busy_while_full", busy, 1'b1);
    phy_wr_full = 1'b0;
    clr = cyc + 1;
    wait_push(p0 + 1, 5, "t4_hdr_wait");
    if (push_cyc.size() > 0) chk("t4_push_after_clear", push_cyc[push_cyc.size()-1], clr);
    phy_rd_en = 1'b1; phy_rd_data = 8'h01; step();
    phy_rd_en = 1'b0;
    wait_done(done_cnt + 1, 10, "t4_done_wait");

    // T5: READ with no response times out
    exp_push.push_back(8'h31); add_done(1, 1'b1);
    issue(1, 4'h3, 4'd1);
    wait_done(done_cnt + 1, 40, "t5_done_wait");
    chk("t5_timeout_latency", done_cyc - push_cyc[push_cyc.size()-1], 17);

    // T6: response on the timeout-compare cycle is accepted
    exp_push.push_back(8'h31); add_rsp(0, 8'h99); add_done(0, 1'b0);
    issue(0, 4'h3, 4'd1);
    wait_push(push_cnt + 1, 10, "t6_hdr_wait");
    repeat (15) step();
    phy_rd_en = 1'b1; phy_rd_data = 8'h99; step();
    phy_rd_en = 1'b0;
    wait_done(done_cnt + 1, 10, "t6_done_wait");
    chk("t6_boundary_latency", done_cyc - push_cyc[push_cyc.size()-1], 17);

    // T7: illegal command and zero-length WRITE never reach the PHY
    p0 = push_cnt;
    add_done(0, 1'b1);
    issue(0, 4'hF, 4'd2);
    wait_done(done_cnt + 1, 10, "t7_illegal_wait");
    add_done(1, 1'b0);
    issue(1, 4'h2, 4'd0);
    wait_done(done_cnt + 1, 10, "t7_noop_wait");
    chk("t7_no_push", push_cnt, p0);

    // stray read-back byte in IDLE is dropped
    r0 = rsp_cnt;
    phy_rd_en = 1'b1; phy_rd_data = 8'hEE; step();
    phy_rd_en = 1'b0;
    repeat (3) step();
    chk("stray_no_rsp", rsp_cnt, r0);
    chk("stray_idle", busy, 1'b0);

    // T8: reset during WDATA, then a clean transaction
    wq0 = '{8'h01, 8'h02, 8'h03}; upd_wdata();
    exp_push.push_back(8'h23); exp_push.push_back(8'h01);
    issue(0, 4'h2, 4'd3);
    wait_push(push_cnt + 2, 10, "t8_push_wait");
    rst = 1'b1;
    #1;
    chk("t8_reset_outputs", outs(), '0);
    wq0.delete(); req_valid = '0; upd_wdata();
    step(); step();
    rst = 1'b0;
    step();
    chk("t8_idle_after_reset", busy, 1'b0);
    wq0 = '{8'h77}; upd_wdata();
    exp_push.push_back(8'h21); exp_push.push_back(8'h77); add_done(0, 1'b0);
    issue(0, 4'h2, 4'd1);
    wait_done(done_cnt + 1, 20, "t8_clean_wait");

    repeat (2) step();
    chk("final_push_queue", exp_push.size(), 0);
    chk("final_rsp_queue", exp_rsp.size(), 0);
    chk("final_done_queue", exp_done.size(), 0);
    chk("final_rd_pulses_r0", rd_cnt0, 7);
    chk("final_rd_pulses_r1", rd_cnt1, 1);
    stim_done = 1'b1;
  endtask

  initial begin
    fork
      begin
        while (!stim_done) monitor_once();
      end
      begin
        stimulus();
      end
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
